// File: rtl/bp_be_fe_queue_replay.sv
// Replay buffer between the FE fetch output and the BE scheduler. Entries stay
// resident after issue until committed, so a roll can replay them in order.
module bp_be_fe_queue_replay #(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_n_i,

  input  logic [width_p-1:0] fe_queue_i,
  input  logic               fe_queue_v_i,
  output logic               fe_queue_ready_o,

  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,

  input  logic               fe_queue_deq_i,
  input  logic               fe_queue_roll_i,
  input  logic               fe_queue_clr_i,

  output logic               empty_o,
  output logic               full_o
);

  localparam int ptr_width_lp = $clog2(els_p) + 1;
  localparam int idx_width_lp = ptr_width_lp - 1;

  logic [width_p-1:0]      mem [els_p];
  logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic                    enq;

  // Handshakes: the FE side is valid/ready -- a packet transfers on a cycle
  // where fe_queue_v_i and fe_queue_ready_o are both 1 (and no clr). The
  // scheduler side is valid/yumi -- yumi may only be raised while
  // fe_queue_v_o is 1 and consumes fe_queue_o in that same cycle.
  assign fe_queue_v_o     = (rptr_r != wptr_r);
  assign fe_queue_o       = mem[rptr_r[idx_width_lp-1:0]];
  assign empty_o          = (wptr_r == cptr_r);
  assign full_o           = (wptr_r[idx_width_lp-1:0] == cptr_r[idx_width_lp-1:0])
                          & (wptr_r[ptr_width_lp-1] != cptr_r[ptr_width_lp-1]);
  // Ready looks only at registered pointers, so a same-cycle deq cannot free a slot.
  assign fe_queue_ready_o = ~full_o;

  assign enq = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;

  always_comb begin
    cptr_n = cptr_r + {{(ptr_width_lp-1){1'b0}}, fe_queue_deq_i};
    rptr_n = fe_queue_roll_i ? cptr_n
                             : rptr_r + {{(ptr_width_lp-1){1'b0}}, fe_queue_yumi_i};
    wptr_n = fe_queue_clr_i ? rptr_n
                            : wptr_r + {{(ptr_width_lp-1){1'b0}}, enq};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r[idx_width_lp-1:0]] <= fe_queue_i;
  end

  // Protocol misuse is caught in simulation only; the datapath does not guard it.
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_yumi_i |-> fe_queue_v_o);
  a_deq_needs_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_deq_i |-> (cptr_r != rptr_r));

endmodule

// File: tb/tb_bp_be_fe_queue_replay.sv
// Directed bench for bp_be_fe_queue_replay: drivers queue the expected packet
// for every yumi, and a monitor compares whenever the scheduler consumes one.
module tb_bp_be_fe_queue_replay;

  localparam int W = 128;
  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         fe_queue_deq_i;
  logic         fe_queue_roll_i;
  logic         fe_queue_clr_i;
  logic         empty_o;
  logic         full_o;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  localparam logic [W-1:0] PA = 128'hAAAA_0001_1111_2222_3333_4444_5555_0A0A;
  localparam logic [W-1:0] PB = 128'hBBBB_0002_6666_7777_8888_9999_AAAA_0B0B;
  localparam logic [W-1:0] PC = 128'hCCCC_0003_BBBB_CCCC_DDDD_EEEE_FFFF_0C0C;
  localparam logic [W-1:0] PD = 128'hDDDD_0004_0123_4567_89AB_CDEF_0000_0D0D;
  localparam logic [W-1:0] PE = 128'hEEEE_0005_FEDC_BA98_7654_3210_1111_0E0E;
  localparam logic [W-1:0] PX = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  bp_be_fe_queue_replay #(.els_p(N), .width_p(W)) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .fe_queue_deq_i   (fe_queue_deq_i),
    .fe_queue_roll_i  (fe_queue_roll_i),
    .fe_queue_clr_i   (fe_queue_clr_i),
    .empty_o          (empty_o),
    .full_o           (full_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n           = 1'b0;
    fe_queue_i      = '0;
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    fe_queue_deq_i  = 1'b0;
    fe_queue_roll_i = 1'b0;
    fe_queue_clr_i  = 1'b0;
  end

  function automatic logic [W-1:0] pkt(input int k);
    pkt = {32'h5A5A_0000 + 32'(k), 64'h0123_4567_89AB_CDEF, 32'(k * 7 + 3)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: hold one cycle's worth of inputs across a rising edge
  task automatic step(input logic v, input logic [W-1:0] d, input logic y,
                      input logic dq, input logic rl, input logic cl);
    fe_queue_v_i    = v;
    fe_queue_i      = d;
    fe_queue_yumi_i = y;
    fe_queue_deq_i  = dq;
    fe_queue_roll_i = rl;
    fe_queue_clr_i  = cl;
    @(posedge clk);
    #1;
    fe_queue_v_i    = 1'b0;
    fe_queue_i      = '0;
    fe_queue_yumi_i = 1'b0;
    fe_queue_deq_i  = 1'b0;
    fe_queue_roll_i = 1'b0;
    fe_queue_clr_i  = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic yumi(input logic [W-1:0] exp);
    exp_q.push_back(exp);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic deq();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // scoreboard monitor: a yumi outside a roll cycle consumes one packet
  always @(negedge clk) begin
    if (rst_n && fe_queue_yumi_i && !fe_queue_roll_i) begin
      checks++;
      if (!fe_queue_v_o) begin
        failures++;
        $display("FAIL yumi_valid: got v_o=0 expected v_o=1");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL yumi_unexpected: got %h expected no consume", fe_queue_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (fe_queue_o !== e) begin
          failures++;
          $display("FAIL yumi_data: got %h expected %h", fe_queue_o, e);
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_empty", W'(empty_o), W'(1));
    check("rst_full",  W'(full_o), W'(0));
    check("rst_ready", W'(fe_queue_ready_o), W'(1));
    check("rst_v",     W'(fe_queue_v_o), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // in-order delivery, no bypass into an empty buffer
    check("pre_push_v", W'(fe_queue_v_o), W'(0));
    push(PA);
    check("first_v", W'(fe_queue_v_o), W'(1));
    check("first_data", fe_queue_o, PA);
    push(PB);
    push(PC);
    yumi(PA);
    yumi(PB);
    yumi(PC);
    check("drained_v", W'(fe_queue_v_o), W'(0));
    check("issued_not_empty", W'(empty_o), W'(0));

    // commit all, fill to full, refuse a 9th, ready returns only after deq
    deq(); deq(); deq();
    check("commit_empty", W'(empty_o), W'(1));
    for (int k = 0; k < N; k++) begin
      check("fill_not_full", W'(full_o), W'(0));
      push(pkt(k));
    end
    check("full", W'(full_o), W'(1));
    check("full_ready", W'(fe_queue_ready_o), W'(0));
    push(PX);
    check("still_full", W'(full_o), W'(1));
    yumi(pkt(0));
    check("yumi_no_free", W'(fe_queue_ready_o), W'(0));
    deq();
    check("deq_ready", W'(fe_queue_ready_o), W'(1));
    check("deq_not_full", W'(full_o), W'(0));
    for (int k = 1; k < N; k++) yumi(pkt(k));
    check("x_dropped_v", W'(fe_queue_v_o), W'(0));
    for (int k = 1; k < N; k++) deq();
    check("drain_empty", W'(empty_o), W'(1));

    // roll replays from the oldest uncommitted entry
    push(PA); push(PB); push(PC); push(PD);
    yumi(PA); yumi(PB); yumi(PC);
    deq();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("roll_v", W'(fe_queue_v_o), W'(1));
    check("roll_data", fe_queue_o, PB);
    yumi(PB); yumi(PC); yumi(PD);
    deq();
    check("after_deq_b", W'(empty_o), W'(0));
    deq(); deq();
    check("roll_empty", W'(empty_o), W'(1));

    // clr drops unissued entries and a same-cycle FE packet
    push(PA); push(PB); push(PC); push(PD);
    yumi(PA); yumi(PB);
    step(1'b1, PE, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_v", W'(fe_queue_v_o), W'(0));
    check("clr_not_empty", W'(empty_o), W'(0));
    deq(); deq();
    check("clr_empty", W'(empty_o), W'(1));
    check("clr_e_dropped", W'(fe_queue_v_o), W'(0));

    // deq+roll+yumi: replay begins after the newly committed entry, yumi ignored
    push(PA); push(PB); push(PC);
    yumi(PA); yumi(PB);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("dry_data", fe_queue_o, PB);
    yumi(PB); yumi(PC);
    deq(); deq();
    check("dry_empty", W'(empty_o), W'(1));

    // full at a wrapped offset, then steady-state streaming across wraps
    for (int k = 0; k < N; k++) push(pkt(100 + k));
    check("wrap_full", W'(full_o), W'(1));
    for (int k = 0; k < N; k++) yumi(pkt(100 + k));
    for (int k = 0; k < N; k++) deq();
    check("wrap_drain_empty", W'(empty_o), W'(1));
    for (int k = 0; k < 20; k++) begin
      push(pkt(200 + k));
      check("stream_not_empty", W'(empty_o), W'(0));
      yumi(pkt(200 + k));
      deq();
      check("stream_empty", W'(empty_o), W'(1));
    end

    // asynchronous reset mid-stream
    push(PA); push(PB);
    yumi(PA);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_empty", W'(empty_o), W'(1));
    check("async_rst_v", W'(fe_queue_v_o), W'(0));
    check("async_rst_full", W'(full_o), W'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(PE);
    check("post_rst_v", W'(fe_queue_v_o), W'(1));
    check("post_rst_data", fe_queue_o, PE);
    yumi(PE);
    deq();
    check("post_rst_empty", W'(empty_o), W'(1));

    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
